axi_rd_arbiter_n: RTL and testbench

- Parametrised N-master AXI4 read-channel arbiter. Muxes NM read masters (IFU, LSU, DMA, …) onto one AXI4 read port toward the memory/crossbar side.
- Generalises the fixed two-master read path with:
  - configurable master count, data width and ID width;
  - selectable round-robin or fixed-priority arbitration;
  - per-burst beat counting with an rlast protocol check.
- The write channel is out of scope; it is handled by a separate block.

---
 rtl/axi_rd_arbiter_n.sv | 206 ++++++++++++++++++++
 tb/tb_axi_rd_arbiter_n.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter_n.sv
// -----------------------------------------------------------------------------
// axi_rd_arbiter_n
// Multiplexes NM AXI4 read masters onto a single AXI4 read port. One burst is
// outstanding at a time. The owner is chosen in IDLE by round-robin
// (RR_MODE=1) or fixed priority with master 0 highest (RR_MODE=0). The owner's
// AR request is forwarded in ADDR, and its R beats are routed back in DATA.
// Beats are counted against the latched arlen, and err_rlast pulses on any
// rlast/beat-count disagreement.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   m_ar*             per-master AR channel (packed, master i at [i*W +: W])
//   m_arready         per-master AR ready (only the owner's can be high)
//   m_rready/m_rvalid per-master R handshake (only the owner's is routed)
//   m_r{data,resp,last,id}  R payload broadcast to all masters
//   s_ar*, s_r*       single AXI4 read port toward memory/crossbar
//   grant             one-hot current owner, zero while IDLE
//   err_rlast         one-cycle pulse on rlast protocol mismatch
// -----------------------------------------------------------------------------
module axi_rd_arbiter_n #(
  parameter int NM      = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int IDW     = 4,
  parameter int RR_MODE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NM-1:0]       m_arvalid,
  output logic [NM-1:0]       m_arready,
  input  logic [NM*AW-1:0]    m_araddr,
  input  logic [NM*IDW-1:0]   m_arid,
  input  logic [NM*8-1:0]     m_arlen,
  input  logic [NM*3-1:0]     m_arsize,
  input  logic [NM*2-1:0]     m_arburst,
  input  logic [NM-1:0]       m_rready,
  output logic [NM-1:0]       m_rvalid,
  output logic [DW-1:0]       m_rdata,
  output logic [1:0]          m_rresp,
  output logic                m_rlast,
  output logic [IDW-1:0]      m_rid,
  output logic                s_arvalid,
  input  logic                s_arready,
  output logic [AW-1:0]       s_araddr,
  output logic [IDW-1:0]      s_arid,
  output logic [7:0]          s_arlen,
  output logic [2:0]          s_arsize,
  output logic [1:0]          s_arburst,
  input  logic                s_rvalid,
  output logic                s_rready,
  input  logic [DW-1:0]       s_rdata,
  input  logic [1:0]          s_rresp,
  input  logic                s_rlast,
  input  logic [IDW-1:0]      s_rid,
  output logic [NM-1:0]       grant,
  output logic                err_rlast
);

  localparam int PW = (NM > 1) ? $clog2(NM) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [NM-1:0] grant_q, grant_d;
  logic [PW-1:0] own_q, own_d;       // binary index of the owner, drives the muxes
  logic [PW-1:0] rr_ptr_q, rr_ptr_d; // highest-priority master for the next round
  logic [8:0]    beat_cnt_q, beat_cnt_d;
  logic [7:0]    len_q, len_d;
  logic [PW-1:0] win_idx_s;
  logic [PW-1:0] own_next_s;

  // Unpacked views of the packed AR fields so the owner mux is a plain index.
  logic [AW-1:0]  araddr_a  [NM];
  logic [IDW-1:0] arid_a    [NM];
  logic [7:0]     arlen_a   [NM];
  logic [2:0]     arsize_a  [NM];
  logic [1:0]     arburst_a [NM];

  for (genvar i = 0; i < NM; i++) begin : g_unpack
    assign araddr_a[i]  = m_araddr[i*AW +: AW];
    assign arid_a[i]    = m_arid[i*IDW +: IDW];
    assign arlen_a[i]   = m_arlen[i*8 +: 8];
    assign arsize_a[i]  = m_arsize[i*3 +: 3];
    assign arburst_a[i] = m_arburst[i*2 +: 2];
  end

  // Scanning from the highest offset down lets the lowest offset (nearest to
  // ptr) overwrite the result last, so it wins without any priority chain.
  function automatic logic [PW-1:0] pick_winner(input logic [NM-1:0] req,
                                                input logic [PW-1:0] ptr);
    logic [PW-1:0] idx;
    logic [PW-1:0] pos;
    idx = '0;
    for (int k = NM - 1; k >= 0; k--) begin
      pos = (RR_MODE != 0) ? PW'((int'(ptr) + k) % NM) : PW'(k);
      idx = req[pos] ? pos : idx;
    end
    return idx;
  endfunction

  assign win_idx_s  = pick_winner(m_arvalid, rr_ptr_q);
  assign own_next_s = (own_q == PW'(NM - 1)) ? '0 : own_q + PW'(1);

  // AR fields always follow the owner index (master 0 after reset).
  assign s_araddr  = araddr_a[own_q];
  assign s_arid    = arid_a[own_q];
  assign s_arlen   = arlen_a[own_q];
  assign s_arsize  = arsize_a[own_q];
  assign s_arburst = arburst_a[own_q];

  // R payload is broadcast; routing is done purely through m_rvalid.
  assign m_rdata = s_rdata;
  assign m_rresp = s_rresp;
  assign m_rlast = s_rlast;
  assign m_rid   = s_rid;

  assign grant = grant_q;

  // State and bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      own_q      <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= 9'd0;
      len_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      own_q      <= own_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
    end
  end

  // Next-state logic and the handshake routing between owner and slave.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    own_d      = own_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    m_arready  = '0;
    m_rvalid   = '0;
    err_rlast  = 1'b0;

    case (state_q)
      IDLE: begin
        if (|m_arvalid) begin
          own_d   = win_idx_s;
          grant_d = {{(NM-1){1'b0}}, 1'b1} << win_idx_s;
          state_d = ADDR;
        end else begin
          state_d = IDLE;
        end
      end

      ADDR: begin
        s_arvalid        = m_arvalid[own_q];
        m_arready[own_q] = s_arready;
        if (m_arvalid[own_q] && s_arready) begin
          len_d      = arlen_a[own_q];
          beat_cnt_d = 9'd0;
          state_d    = DATA;
        end else begin
          state_d = ADDR;
        end
      end

      DATA: begin
        s_rready        = m_rready[own_q];
        m_rvalid[own_q] = s_rvalid;
        if (s_rvalid && m_rready[own_q]) begin
          // beat_cnt_q counts beats already taken, so the last beat sees len.
          beat_cnt_d = (beat_cnt_q == 9'd511) ? beat_cnt_q : beat_cnt_q + 9'd1;
          err_rlast  = s_rlast ? (beat_cnt_q != {1'b0, len_q})
                               : (beat_cnt_q == {1'b0, len_q});
          if (s_rlast) begin
            state_d  = IDLE;
            grant_d  = '0;
            rr_ptr_d = (RR_MODE != 0) ? own_next_s : rr_ptr_q;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_axi_rd_arbiter_n.sv
// -----------------------------------------------------------------------------
// tb_axi_rd_arbiter_n
// Directed bench for axi_rd_arbiter_n. A four-master fixed-priority instance
// (f_*) covers ordering, AR stall, R backpressure and rlast errors. A
// two-master round-robin instance (r_*) covers alternation and reset mid-burst.
// -----------------------------------------------------------------------------
module tb_axi_rd_arbiter_n;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- fixed-priority instance, NM=4 ----------------
  logic [3:0]   f_arvalid, f_m_arready, f_rready, f_m_rvalid, f_grant;
  logic [127:0] f_araddr;
  logic [15:0]  f_arid;
  logic [31:0]  f_arlen;
  logic [11:0]  f_arsize;
  logic [7:0]   f_arburst;
  logic [31:0]  f_m_rdata, f_s_araddr, f_s_rdata;
  logic [1:0]   f_m_rresp, f_s_rresp, f_s_arburst;
  logic         f_m_rlast, f_s_rlast, f_err;
  logic [3:0]   f_m_rid, f_s_arid, f_s_rid;
  logic         f_s_arvalid, f_s_arready, f_s_rvalid, f_s_rready;
  logic [7:0]   f_s_arlen;
  logic [2:0]   f_s_arsize;

  axi_rd_arbiter_n #(.NM(4), .AW(32), .DW(32), .IDW(4), .RR_MODE(0)) u_fp (
    .clk(clk), .rst(rst),
    .m_arvalid(f_arvalid), .m_arready(f_m_arready), .m_araddr(f_araddr),
    .m_arid(f_arid), .m_arlen(f_arlen), .m_arsize(f_arsize), .m_arburst(f_arburst),
    .m_rready(f_rready), .m_rvalid(f_m_rvalid), .m_rdata(f_m_rdata),
    .m_rresp(f_m_rresp), .m_rlast(f_m_rlast), .m_rid(f_m_rid),
    .s_arvalid(f_s_arvalid), .s_arready(f_s_arready), .s_araddr(f_s_araddr),
    .s_arid(f_s_arid), .s_arlen(f_s_arlen), .s_arsize(f_s_arsize),
    .s_arburst(f_s_arburst), .s_rvalid(f_s_rvalid), .s_rready(f_s_rready),
    .s_rdata(f_s_rdata), .s_rresp(f_s_rresp), .s_rlast(f_s_rlast), .s_rid(f_s_rid),
    .grant(f_grant), .err_rlast(f_err)
  );

  // ---------------- round-robin instance, NM=2 ----------------
  logic [1:0]   r_arvalid, r_m_arready, r_rready, r_m_rvalid, r_grant;
  logic [63:0]  r_araddr;
  logic [7:0]   r_arid;
  logic [15:0]  r_arlen;
  logic [5:0]   r_arsize;
  logic [3:0]   r_arburst;
  logic [31:0]  r_m_rdata, r_s_araddr, r_s_rdata;
  logic [1:0]   r_m_rresp, r_s_rresp, r_s_arburst;
  logic         r_m_rlast, r_s_rlast, r_err;
  logic [3:0]   r_m_rid, r_s_arid, r_s_rid;
  logic         r_s_arvalid, r_s_arready, r_s_rvalid, r_s_rready;
  logic [7:0]   r_s_arlen;
  logic [2:0]   r_s_arsize;

  axi_rd_arbiter_n #(.NM(2), .AW(32), .DW(32), .IDW(4), .RR_MODE(1)) u_rr (
    .clk(clk), .rst(rst),
    .m_arvalid(r_arvalid), .m_arready(r_m_arready), .m_araddr(r_araddr),
    .m_arid(r_arid), .m_arlen(r_arlen), .m_arsize(r_arsize), .m_arburst(r_arburst),
    .m_rready(r_rready), .m_rvalid(r_m_rvalid), .m_rdata(r_m_rdata),
    .m_rresp(r_m_rresp), .m_rlast(r_m_rlast), .m_rid(r_m_rid),
    .s_arvalid(r_s_arvalid), .s_arready(r_s_arready), .s_araddr(r_s_araddr),
    .s_arid(r_s_arid), .s_arlen(r_s_arlen), .s_arsize(r_s_arsize),
    .s_arburst(r_s_arburst), .s_rvalid(r_s_rvalid), .s_rready(r_s_rready),
    .s_rdata(r_s_rdata), .s_rresp(r_s_rresp), .s_rlast(r_s_rlast), .s_rid(r_s_rid),
    .grant(r_grant), .err_rlast(r_err)
  );

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One burst on the fixed-priority instance. Entry: FSM in IDLE with master m
  // the winning requester. last = beat index carrying rlast. tog toggles
  // m_rready 1,0,1,0... late is a request mask raised once DATA is entered.
  task automatic f_burst(input int m, input int len, input int last, input bit tog,
                         input logic [3:0] late, input bit stall);
    int   b;
    int   c;
    bit   done;
    logic exp_err;
    f_arlen[m*8 +: 8] = 8'(len);
    f_s_arready = !stall;
    step();
    check_val("f_addr_grant",   f_grant, 64'(1 << m));
    check_val("f_addr_arvalid", f_s_arvalid, 64'd1);
    check_val("f_addr_araddr",  f_s_araddr, 64'(32'h1000_0000 + 32'(256 * m)));
    check_val("f_addr_arid",    f_s_arid, 64'(m + 5));
    check_val("f_addr_arlen",   f_s_arlen, 64'(len));
    check_val("f_addr_arsize",  f_s_arsize, 64'(m));
    check_val("f_addr_arready", f_m_arready, stall ? 64'd0 : 64'(1 << m));
    if (stall) begin
      step();
      check_val("f_stall_grant",   f_grant, 64'(1 << m));
      check_val("f_stall_arvalid", f_s_arvalid, 64'd1);
      f_s_arready = 1'b1;
      #1;
      check_val("f_stall_arready", f_m_arready, 64'(1 << m));
    end
    step();
    f_arvalid[m] = 1'b0;
    f_arvalid    = f_arvalid | late;
    #1;
    check_val("f_data_arvalid", f_s_arvalid, 64'd0);
    b    = 0;
    c    = 0;
    done = 1'b0;
    while (!done && c < 32) begin
      f_rready[m] = tog ? (c % 2 == 0) : 1'b1;
      f_s_rvalid  = 1'b1;
      f_s_rlast   = (b == last);
      f_s_rdata   = 32'hD000_0000 + 32'(m * 16 + b);
      f_s_rid     = 4'(b + 1);
      #1;
      exp_err = f_rready[m] && ((b == last) ? (b != len) : (b == len));
      check_val("f_beat_rready",  f_s_rready, 64'(f_rready[m]));
      check_val("f_beat_rvalid",  f_m_rvalid, 64'(1 << m));
      check_val("f_beat_rdata",   f_m_rdata, 64'(32'hD000_0000 + 32'(m * 16 + b)));
      check_val("f_beat_rid",     f_m_rid, 64'(b + 1));
      check_val("f_beat_arready", f_m_arready, 64'd0);
      check_val("f_beat_err",     f_err, 64'(exp_err));
      if (f_rready[m]) begin
        done = (b == last);
        b++;
      end
      step();
      c++;
    end
    f_s_rvalid  = 1'b0;
    f_s_rlast   = 1'b0;
    f_rready[m] = 1'b1;
    #1;
    check_val("f_done",        64'(done), 64'd1);
    check_val("f_idle_grant",  f_grant, 64'd0);
    check_val("f_idle_rvalid", f_m_rvalid, 64'd0);
  endtask

  initial begin
    rst         = 1'b1;
    f_arvalid   = 4'd0;
    f_rready    = 4'hF;
    f_arlen     = 32'd0;
    f_s_arready = 1'b1;
    f_s_rvalid  = 1'b0;
    f_s_rlast   = 1'b0;
    f_s_rdata   = 32'd0;
    f_s_rresp   = 2'd0;
    f_s_rid     = 4'd0;
    for (int m = 0; m < 4; m++) begin
      f_araddr[m*32 +: 32] = 32'h1000_0000 + 32'(256 * m);
      f_arid[m*4 +: 4]     = 4'(m + 5);
      f_arsize[m*3 +: 3]   = 3'(m);
      f_arburst[m*2 +: 2]  = 2'(m);
    end
    r_arvalid   = 2'b00;
    r_araddr    = {32'h2000_0100, 32'h2000_0000};
    r_arid      = {4'h9, 4'h8};
    r_arlen     = 16'd0;
    r_arsize    = 6'd0;
    r_arburst   = 4'd0;
    r_rready    = 2'b11;
    r_s_arready = 1'b1;
    r_s_rvalid  = 1'b1;
    r_s_rlast   = 1'b1;
    r_s_rdata   = 32'hCAFE_0000;
    r_s_rresp   = 2'd0;
    r_s_rid     = 4'd3;

    repeat (2) @(posedge clk);
    #1;
    check_val("rst_f_grant",   f_grant, 64'd0);
    check_val("rst_f_arvalid", f_s_arvalid, 64'd0);
    check_val("rst_f_rready",  f_s_rready, 64'd0);
    check_val("rst_f_arready", f_m_arready, 64'd0);
    check_val("rst_f_rvalid",  f_m_rvalid, 64'd0);
    check_val("rst_f_err",     f_err, 64'd0);
    check_val("rst_f_araddr",  f_s_araddr, 64'h1000_0000);
    check_val("rst_r_grant",   r_grant, 64'd0);
    check_val("rst_r_rvalid",  r_m_rvalid, 64'd0);

    // Fixed priority: 1, 2, 3 requesting together, first one with an AR stall.
    f_arvalid = 4'b1110;
    rst       = 1'b0;
    f_burst(1, 3, 3, 1'b0, 4'b0000, 1'b1);
    f_burst(2, 3, 3, 1'b0, 4'b0000, 1'b0);
    f_burst(3, 3, 3, 1'b0, 4'b0000, 1'b0);
    // R backpressure on master 2.
    f_arvalid = 4'b0100;
    f_burst(2, 3, 3, 1'b1, 4'b0000, 1'b0);
    // Early rlast on beat 2 while master 1 raises a request mid-burst.
    f_arvalid = 4'b0001;
    f_burst(0, 3, 1, 1'b0, 4'b0010, 1'b0);
    f_burst(1, 3, 3, 1'b0, 4'b0000, 1'b0);
    // Missing rlast on the final beat, then a late rlast one beat past len.
    f_arvalid = 4'b1000;
    f_burst(3, 1, 2, 1'b0, 4'b0000, 1'b0);

    // Round robin with single-beat bursts; reset lands in the 4th DATA cycle.
    r_arvalid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      step();
      check_val("r_addr_grant",   r_grant, 64'(1 << (k % 2)));
      check_val("r_addr_arvalid", r_s_arvalid, 64'd1);
      check_val("r_addr_araddr",  r_s_araddr, (k % 2) ? 64'h2000_0100 : 64'h2000_0000);
      check_val("r_addr_arready", r_m_arready, 64'(1 << (k % 2)));
      check_val("r_addr_rvalid",  r_m_rvalid, 64'd0);
      step();
      if (k == 3) begin
        rst = 1'b1;
        #1;
        check_val("r_rst_grant",   r_grant, 64'd0);
        check_val("r_rst_rready",  r_s_rready, 64'd0);
        check_val("r_rst_arvalid", r_s_arvalid, 64'd0);
        check_val("r_rst_rvalid",  r_m_rvalid, 64'd0);
      end else begin
        check_val("r_data_rvalid", r_m_rvalid, 64'(1 << (k % 2)));
        check_val("r_data_rready", r_s_rready, 64'd1);
        check_val("r_data_rdata",  r_m_rdata, 64'hCAFE_0000);
        check_val("r_data_err",    r_err, 64'd0);
        step();
        check_val("r_idle_grant",  r_grant, 64'd0);
        check_val("r_idle_rvalid", r_m_rvalid, 64'd0);
      end
    end
    step();
    rst = 1'b0;
    step();
    check_val("r_post_rst_grant",   r_grant, 64'd1);
    check_val("r_post_rst_arvalid", r_s_arvalid, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1);
  end

endmodule
